// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types used by the rectangle fill engine
// and the output stage.
package vga_pkg;

    localparam int H_VISIBLE    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int H_TOTAL      = H_SYNC_END + H_BACK;

    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int V_TOTAL      = V_SYNC_END + V_BACK;

    localparam int PX_X_W = 10;
    localparam int PX_Y_W = 9;

    typedef struct packed {
        logic [PX_X_W-1:0] x;
        logic [PX_Y_W-1:0] y;
        logic [7:0]        r;
        logic [7:0]        g;
        logic [7:0]        b;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        EMIT,
        FIN
    } rect_state_e;

endpackage

// File: rtl/vga_raster_counter.sv
// Loadable raster-order x/y walker over an inclusive [xl..xr] x [yt..yb] window.
// Shared by the fill engine and later blit/clear blocks.
module vga_raster_counter #(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           advance,
    input  logic [X_W-1:0] xl,
    input  logic [X_W-1:0] xr,
    input  logic [Y_W-1:0] yt,
    input  logic [Y_W-1:0] yb,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           last
);

    assign last = (cx == xr) && (cy == yb);

    // Advancing at the final pixel holds position, so the counter can never run past xr/yb.
    always_ff @(posedge clk) begin
        if (rst) begin
            cx <= '0;
            cy <= '0;
        end else if (load) begin
            cx <= xl;
            cy <= yt;
        end else if (advance) begin
            if (cx != xr) begin
                cx <= cx + 1'b1;
            end else if (cy != yb) begin
                cx <= xl;
                cy <= cy + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: emits every visible pixel of one command rectangle
// in raster order over a valid/ready beat interface.
//
// state | meaning
// IDLE  | waiting for start; command inputs latched on start
// SETUP | normalised/clipped bounds settle; counter loaded or command found empty
// EMIT  | one beat per px_valid & px_ready transfer
// FIN   | one-cycle done pulse, then back to IDLE
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter int H_RES = H_VISIBLE,
    parameter int V_RES = V_VISIBLE,
    parameter int X_W   = 10,
    parameter int Y_W   = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    input  logic [7:0]     r_cmd,
    input  logic [7:0]     g_cmd,
    input  logic [7:0]     b_cmd,
    output logic           busy,
    output logic           done,
    output logic           px_valid,
    input  logic           px_ready,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [7:0]     r_out,
    output logic [7:0]     g_out,
    output logic [7:0]     b_out
);

    localparam logic [X_W-1:0] X_LIMIT = X_W'(H_RES);
    localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(V_RES);
    localparam logic [X_W-1:0] X_LAST  = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_RES - 1);

    rect_state_e state;

    logic [X_W-1:0] x0_q, x1_q;
    logic [Y_W-1:0] y0_q, y1_q;

    logic [X_W-1:0] xl, xr_raw, xr;
    logic [Y_W-1:0] yt, yb_raw, yb;
    logic           empty;

    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic           last;
    logic           load;
    logic           advance;
    logic           transfer;

    // Bounds derive from the latched corners, so they stay stable for the whole command.
    always_comb begin
        xl     = (x0_q < x1_q) ? x0_q : x1_q;
        xr_raw = (x0_q < x1_q) ? x1_q : x0_q;
        yt     = (y0_q < y1_q) ? y0_q : y1_q;
        yb_raw = (y0_q < y1_q) ? y1_q : y0_q;
        xr     = (xr_raw > X_LAST) ? X_LAST : xr_raw;
        yb     = (yb_raw > Y_LAST) ? Y_LAST : yb_raw;
        empty  = (xl >= X_LIMIT) || (yt >= Y_LIMIT);
    end

    assign transfer = (state == EMIT) && px_valid && px_ready;
    assign load     = (state == SETUP) && !empty;
    assign advance  = transfer && !last;

    vga_raster_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .xl      (xl),
        .xr      (xr),
        .yt      (yt),
        .yb      (yb),
        .cx      (cx),
        .cy      (cy),
        .last    (last)
    );

    assign x_out = cx;
    assign y_out = cy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            px_valid <= 1'b0;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            r_out    <= '0;
            g_out    <= '0;
            b_out    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x0_q  <= x0;
                        x1_q  <= x1;
                        y0_q  <= y0;
                        y1_q  <= y1;
                        r_out <= r_cmd;
                        g_out <= g_cmd;
                        b_out <= b_cmd;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (empty) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        px_valid <= 1'b1;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (transfer && last) begin
                        px_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: fixed commands with hand-computed beat sequences.
module tb_vga_rect_fill;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] x0 = '0, x1 = '0;
    logic [8:0] y0 = '0, y1 = '0;
    logic [7:0] r_cmd = '0, g_cmd = '0, b_cmd = '0;
    logic       busy, done, px_valid;
    logic       px_ready = 1'b1;
    logic [9:0] x_out;
    logic [8:0] y_out;
    logic [7:0] r_out, g_out, b_out;

    int total = 0;
    int bad = 0;

    pixel_t      beats[64];
    int          beat_cyc[64];
    int          nbeats;
    int          done_cnt;
    int          done_cyc;
    logic        tr_valid[64];
    logic        tr_busy[64];
    logic        tr_done[64];
    logic [9:0]  tr_x[64];
    logic [8:0]  tr_y[64];
    logic [23:0] tr_rgb[64];
    bit          rdy_pat[8];
    int          rdy_len = 0;

    vga_rect_fill dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .r_cmd    (r_cmd),
        .g_cmd    (g_cmd),
        .b_cmd    (b_cmd),
        .busy     (busy),
        .done     (done),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .x_out    (x_out),
        .y_out    (y_out),
        .r_out    (r_out),
        .g_out    (g_out),
        .b_out    (b_out)
    );

    always #5 clk = ~clk;

    // Drives start for one cycle (cycle 0); returns at cycle 1, #1 after the edge.
    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1,
                         input logic [23:0] rgb);
        x0    = 10'(ax0);
        y0    = 9'(ay0);
        x1    = 10'(ax1);
        y1    = 9'(ay1);
        r_cmd = rgb[23:16];
        g_cmd = rgb[15:8];
        b_cmd = rgb[7:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs cycles 1..budget, recording transfers, done pulses and an output trace.
    task automatic collect(input int budget, input int poke_cyc, input int rst_cyc);
        nbeats   = 0;
        done_cnt = 0;
        done_cyc = -1;
        for (int i = 0; i < 64; i++) begin
            beats[i]    = '0;
            beat_cyc[i] = -1;
        end
        for (int c = 1; c <= budget; c++) begin
            px_ready = (c >= 2 && (c - 2) < rdy_len) ? rdy_pat[c - 2] : 1'b1;
            start    = (c == poke_cyc);
            if (c == poke_cyc) begin
                x0 = 10'd100; y0 = 9'd100; x1 = 10'd101; y1 = 9'd101;
                r_cmd = 8'hEE; g_cmd = 8'hEE; b_cmd = 8'hEE;
            end
            rst       = (c == rst_cyc);
            tr_valid[c] = px_valid;
            tr_busy[c]  = busy;
            tr_done[c]  = done;
            tr_x[c]     = x_out;
            tr_y[c]     = y_out;
            tr_rgb[c]   = {r_out, g_out, b_out};
            if (!rst && px_valid && px_ready && nbeats < 64) begin
                beats[nbeats]    = '{x: x_out, y: y_out, r: r_out, g: g_out, b: b_out};
                beat_cyc[nbeats] = c;
                nbeats++;
            end
            if (done) begin
                if (done_cnt == 0) done_cyc = c;
                done_cnt++;
            end
            @(posedge clk); #1;
        end
        start    = 1'b0;
        rst      = 1'b0;
        px_ready = 1'b1;
        rdy_len  = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, px_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl got busy/done/valid=%b want 000", {busy, done, px_valid});
        end
        total++;
        if ({x_out, y_out, r_out, g_out, b_out} !== '0) begin
            bad++;
            $display("FAIL reset_data got x=%0d y=%0d rgb=%h want all zero",
                     x_out, y_out, {r_out, g_out, b_out});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_fill();
        pixel_t exp[4];
        exp[0] = '{x: 10'd2, y: 9'd3, r: 8'hFF, g: 8'h00, b: 8'h80};
        exp[1] = '{x: 10'd3, y: 9'd3, r: 8'hFF, g: 8'h00, b: 8'h80};
        exp[2] = '{x: 10'd2, y: 9'd4, r: 8'hFF, g: 8'h00, b: 8'h80};
        exp[3] = '{x: 10'd3, y: 9'd4, r: 8'hFF, g: 8'h00, b: 8'h80};
        issue(2, 3, 3, 4, 24'hFF0080);
        collect(12, 0, 0);
        total++;
        if (tr_busy[1] !== 1'b1 || tr_valid[1] !== 1'b0) begin
            bad++;
            $display("FAIL basic_setup got busy=%b valid=%b want busy=1 valid=0", tr_busy[1], tr_valid[1]);
        end
        total++;
        if (nbeats != 4) begin
            bad++;
            $display("FAIL basic_count got %0d want 4", nbeats);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (beats[i] !== exp[i] || beat_cyc[i] != 2 + i) begin
                bad++;
                $display("FAIL basic_beat%0d got %h at cyc %0d want %h at cyc %0d",
                         i, beats[i], beat_cyc[i], exp[i], 2 + i);
            end
        end
        total++;
        if (done_cnt != 1 || done_cyc != 6) begin
            bad++;
            $display("FAIL basic_done got cnt=%0d cyc=%0d want cnt=1 cyc=6", done_cnt, done_cyc);
        end
        total++;
        if (tr_busy[6] !== 1'b0 || tr_busy[7] !== 1'b0 || tr_valid[6] !== 1'b0) begin
            bad++;
            $display("FAIL basic_after got busy6=%b busy7=%b valid6=%b want 0 0 0",
                     tr_busy[6], tr_busy[7], tr_valid[6]);
        end
    endtask

    task automatic test_swapped_corners();
        pixel_t exp[4];
        exp[0] = '{x: 10'd2, y: 9'd3, r: 8'hFF, g: 8'h00, b: 8'h80};
        exp[1] = '{x: 10'd3, y: 9'd3, r: 8'hFF, g: 8'h00, b: 8'h80};
        exp[2] = '{x: 10'd2, y: 9'd4, r: 8'hFF, g: 8'h00, b: 8'h80};
        exp[3] = '{x: 10'd3, y: 9'd4, r: 8'hFF, g: 8'h00, b: 8'h80};
        issue(3, 4, 2, 3, 24'hFF0080);
        collect(12, 0, 0);
        total++;
        if (nbeats != 4 || done_cnt != 1 || done_cyc != 6) begin
            bad++;
            $display("FAIL swap_shape got beats=%0d done_cnt=%0d done_cyc=%0d want 4 1 6",
                     nbeats, done_cnt, done_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (beats[i] !== exp[i] || beat_cyc[i] != 2 + i) begin
                bad++;
                $display("FAIL swap_beat%0d got %h at cyc %0d want %h at cyc %0d",
                         i, beats[i], beat_cyc[i], exp[i], 2 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_cyc[3];
        exp_cyc[0] = 2; exp_cyc[1] = 5; exp_cyc[2] = 7;
        rdy_pat[0] = 1; rdy_pat[1] = 0; rdy_pat[2] = 0;
        rdy_pat[3] = 1; rdy_pat[4] = 0; rdy_pat[5] = 1;
        rdy_len = 6;
        issue(10, 0, 12, 0, 24'h123456);
        collect(14, 0, 0);
        total++;
        if (nbeats != 3) begin
            bad++;
            $display("FAIL bp_count got %0d want 3", nbeats);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (beats[i] !== pixel_t'({10'(10 + i), 9'd0, 24'h123456}) || beat_cyc[i] != exp_cyc[i]) begin
                bad++;
                $display("FAIL bp_beat%0d got %h at cyc %0d want x=%0d y=0 rgb=123456 at cyc %0d",
                         i, beats[i], beat_cyc[i], 10 + i, exp_cyc[i]);
            end
        end
        total++;
        if (tr_valid[3] !== 1'b1 || tr_valid[4] !== 1'b1 || tr_x[3] !== 10'd11 || tr_x[4] !== 10'd11
            || tr_rgb[4] !== 24'h123456) begin
            bad++;
            $display("FAIL bp_hold1 got v3=%b v4=%b x3=%0d x4=%0d rgb4=%h want 1 1 11 11 123456",
                     tr_valid[3], tr_valid[4], tr_x[3], tr_x[4], tr_rgb[4]);
        end
        total++;
        if (tr_valid[6] !== 1'b1 || tr_x[6] !== 10'd12 || tr_y[6] !== 9'd0) begin
            bad++;
            $display("FAIL bp_hold2 got v6=%b x6=%0d y6=%0d want 1 12 0", tr_valid[6], tr_x[6], tr_y[6]);
        end
        total++;
        if (done_cnt != 1 || done_cyc != 8) begin
            bad++;
            $display("FAIL bp_done got cnt=%0d cyc=%0d want cnt=1 cyc=8", done_cnt, done_cyc);
        end
    endtask

    task automatic test_clip_and_empty();
        issue(630, 479, 700, 479, 24'hA0B0C0);
        collect(20, 0, 0);
        total++;
        if (nbeats != 10) begin
            bad++;
            $display("FAIL clip_count got %0d want 10", nbeats);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (beats[i] !== pixel_t'({10'(630 + i), 9'd479, 24'hA0B0C0}) || beat_cyc[i] != 2 + i) begin
                bad++;
                $display("FAIL clip_beat%0d got %h at cyc %0d want x=%0d y=479 at cyc %0d",
                         i, beats[i], beat_cyc[i], 630 + i, 2 + i);
            end
        end
        total++;
        if (done_cnt != 1 || done_cyc != 12) begin
            bad++;
            $display("FAIL clip_done got cnt=%0d cyc=%0d want cnt=1 cyc=12", done_cnt, done_cyc);
        end

        issue(650, 10, 650, 20, 24'h010203);
        collect(8, 0, 0);
        total++;
        if (nbeats != 0 || done_cnt != 1 || done_cyc != 2) begin
            bad++;
            $display("FAIL empty got beats=%0d done_cnt=%0d done_cyc=%0d want 0 1 2",
                     nbeats, done_cnt, done_cyc);
        end
        total++;
        if (tr_busy[1] !== 1'b1 || tr_busy[2] !== 1'b0 || tr_valid[1] !== 1'b0 || tr_valid[2] !== 1'b0) begin
            bad++;
            $display("FAIL empty_ctrl got busy1=%b busy2=%b v1=%b v2=%b want 1 0 0 0",
                     tr_busy[1], tr_busy[2], tr_valid[1], tr_valid[2]);
        end
    endtask

    task automatic test_start_while_busy();
        pixel_t exp[4];
        exp[0] = '{x: 10'd5, y: 9'd5, r: 8'h0F, g: 8'h0F, b: 8'h0F};
        exp[1] = '{x: 10'd6, y: 9'd5, r: 8'h0F, g: 8'h0F, b: 8'h0F};
        exp[2] = '{x: 10'd5, y: 9'd6, r: 8'h0F, g: 8'h0F, b: 8'h0F};
        exp[3] = '{x: 10'd6, y: 9'd6, r: 8'h0F, g: 8'h0F, b: 8'h0F};
        issue(5, 5, 6, 6, 24'h0F0F0F);
        collect(16, 3, 0);
        total++;
        if (nbeats != 4 || done_cnt != 1 || done_cyc != 6) begin
            bad++;
            $display("FAIL busy_start got beats=%0d done_cnt=%0d done_cyc=%0d want 4 1 6",
                     nbeats, done_cnt, done_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (beats[i] !== exp[i]) begin
                bad++;
                $display("FAIL busy_beat%0d got %h want %h", i, beats[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(0, 0, 3, 3, 24'h112233);
        collect(12, 0, 4);
        total++;
        if (nbeats != 2 || done_cnt != 0) begin
            bad++;
            $display("FAIL rstmid_count got beats=%0d done_cnt=%0d want 2 0", nbeats, done_cnt);
        end
        total++;
        if ({tr_valid[5], tr_busy[5], tr_done[5]} !== 3'b000 || tr_x[5] !== 10'd0 || tr_y[5] !== 9'd0
            || tr_rgb[5] !== 24'h0) begin
            bad++;
            $display("FAIL rstmid_state got v=%b busy=%b done=%b x=%0d y=%0d rgb=%h want all zero",
                     tr_valid[5], tr_busy[5], tr_done[5], tr_x[5], tr_y[5], tr_rgb[5]);
        end

        issue(7, 8, 7, 8, 24'h445566);
        collect(8, 0, 0);
        total++;
        if (nbeats != 1 || beats[0] !== pixel_t'({10'd7, 9'd8, 24'h445566}) || beat_cyc[0] != 2) begin
            bad++;
            $display("FAIL rstmid_fresh got beats=%0d first=%h at cyc %0d want 1 beat x=7 y=8 rgb=445566 at cyc 2",
                     nbeats, beats[0], beat_cyc[0]);
        end
        total++;
        if (done_cnt != 1 || done_cyc != 3) begin
            bad++;
            $display("FAIL rstmid_done got cnt=%0d cyc=%0d want cnt=1 cyc=3", done_cnt, done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_swapped_corners();
        test_backpressure();
        test_clip_and_empty();
        test_start_while_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
